// File: rtl/block_pkg.sv
// Shared geometry, pixel/block types and per-bank state for the block loader.
package block_pkg;
    localparam int PIXEL_W      = 4;
    localparam int BLOCK_DIM    = 4;
    localparam int BLOCK_PIXELS = BLOCK_DIM * BLOCK_DIM;
    localparam int ROW_W        = $clog2(BLOCK_DIM);
    localparam int IDX_W        = 2 * ROW_W;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef pixel_t [BLOCK_DIM-1:0][BLOCK_DIM-1:0] block_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        BANK_FILLING,
        BANK_FULL,
        BANK_HELD
    } bank_state_e;
endpackage

// File: rtl/block_bank.sv
// One block of pixel registers written in row-major order, one pixel per cycle.
// full sets on the write to the last index and stays set until free_bank.
module block_bank
    import block_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en,
    input  idx_t   wr_idx,
    input  pixel_t wr_pixel,
    input  logic   free_bank,
    output block_t pixels,
    output logic   full
);
    always_ff @(posedge clk) begin
        if (rst) begin
            pixels <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                pixels[wr_idx[IDX_W-1:ROW_W]][wr_idx[ROW_W-1:0]] <= wr_pixel;
            end
            if (free_bank) begin
                full <= 1'b0;
            end else if (wr_en && (wr_idx == idx_t'(BLOCK_PIXELS - 1))) begin
                full <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/block_loader.sv
// Assembles serial pixels into blocks; load_enable one cycle after the last pixel, pixel_ready low while no bank is free.
// BLOCK_LOADER_PINGPONG_EN: two alternating fill banks so filling overlaps the held block; otherwise one bank.
module block_loader #(
    parameter int PIXEL_W   = block_pkg::PIXEL_W,
    parameter int BLOCK_DIM = block_pkg::BLOCK_DIM
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [PIXEL_W-1:0]                             pixel_in,
    input  logic                                           pixel_valid,
    output logic                                           pixel_ready,
    input  logic                                           block_done,
    output logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][PIXEL_W-1:0] block_pixels,
    output logic                                           load_enable,
    output logic                                           busy,
    output logic [15:0]                                    block_count
);
    import block_pkg::*;

`ifdef BLOCK_LOADER_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
    localparam int NB       = 2;
`else
    localparam bit PINGPONG = 1'b0;
    localparam int NB       = 1;
`endif

    bank_state_e     st [NB];
    bank_state_e     st_nxt [NB];
    block_t          bank_pix [NB];
    logic [NB-1:0]   bank_full;
    logic [NB-1:0]   bank_wr;
    logic [NB-1:0]   bank_free;
    logic [NB-1:0]   held;
    logic [NB-1:0]   held_nxt;
    logic [NB-1:0]   full_nxt;
    idx_t            fill_cnt;
    logic            fill_sel;
    logic            fill_sel_nxt;
    logic            accept;
    logic            last;
    logic            load;
    logic            load_sel;
    logic            ready_nxt;

`ifdef BLOCK_LOADER_PINGPONG_EN
    for (genvar b = 0; b < NB; b++) begin : g_bank
        block_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (bank_wr[b]),
            .wr_idx    (fill_cnt),
            .wr_pixel  (pixel_in),
            .free_bank (bank_free[b]),
            .pixels    (bank_pix[b]),
            .full      (bank_full[b])
        );
    end

    // Separate output register: the freed bank refills while the next block is still held.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_pixels <= '0;
        end else if (load) begin
            block_pixels <= bank_pix[load_sel];
        end
    end
`else
    block_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_wr[0]),
        .wr_idx    (fill_cnt),
        .wr_pixel  (pixel_in),
        .free_bank (bank_free[0]),
        .pixels    (bank_pix[0]),
        .full      (bank_full[0])
    );

    // Bank is not written while held, so it is stable whenever busy is high.
    assign block_pixels = bank_pix[0];
`endif

    always_comb begin
        accept   = pixel_valid && pixel_ready;
        last     = accept && (fill_cnt == idx_t'(BLOCK_PIXELS - 1));
        load     = 1'b0;
        load_sel = 1'b0;
        for (int b = 0; b < NB; b++) begin
            held[b]      = (st[b] == BANK_HELD);
            bank_wr[b]   = accept && (fill_sel == 1'(b));
            bank_free[b] = block_done && held[b];
            full_nxt[b]  = (bank_full[b] && !bank_free[b]) || (last && (fill_sel == 1'(b)));
        end
        held_nxt = held & ~bank_free;
        // Issue only when nothing remains held downstream, in the same edge that frees it.
        if (held_nxt == '0) begin
            for (int b = NB - 1; b >= 0; b--) begin
                if (full_nxt[b]) begin
                    load     = 1'b1;
                    load_sel = 1'(b);
                end
            end
        end
        if (load) begin
            held_nxt[load_sel] = 1'b1;
        end
        fill_sel_nxt = (PINGPONG && last) ? !fill_sel : fill_sel;
        for (int b = 0; b < NB; b++) begin
            if (!full_nxt[b]) begin
                st_nxt[b] = BANK_FILLING;
            end else if (held_nxt[b]) begin
                st_nxt[b] = BANK_HELD;
            end else begin
                st_nxt[b] = BANK_FULL;
            end
        end
        ready_nxt = (st_nxt[fill_sel_nxt] == BANK_FILLING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                st[b] <= BANK_FILLING;
            end
            fill_cnt    <= '0;
            fill_sel    <= 1'b0;
            pixel_ready <= 1'b0;
            load_enable <= 1'b0;
            busy        <= 1'b0;
            block_count <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                st[b] <= st_nxt[b];
            end
            if (accept) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            fill_sel    <= fill_sel_nxt;
            pixel_ready <= ready_nxt;
            load_enable <= load;
            busy        <= |held_nxt;
            if (load) begin
                block_count <= block_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_block_loader.sv
// Self-checking bench for block_loader: occupancy-based reference model plus directed literal checks.
module tb_block_loader;
    import block_pkg::*;

`ifdef BLOCK_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        block_done;
    block_t      block_pixels;
    logic        load_enable;
    logic        busy;
    logic [15:0] block_count;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int ofs    = 0;

    always #5 clk = ~clk;

    block_loader dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .block_done   (block_done),
        .block_pixels (block_pixels),
        .load_enable  (load_enable),
        .busy         (busy),
        .block_count  (block_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pv(input int n);
        return (n < 16) ? 4'(n) : 4'(n * 5 + 3);
    endfunction

    function automatic block_t ramp(input int base);
        block_t b;
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = pv(base + i);
        return b;
    endfunction

    // Reference model: a block queue; the loader holds at most NB blocks (held + complete).
    block_t      cur;
    block_t      m_pix;
    block_t      full_q[$];
    int          cnt;
    bit          m_held, m_le, m_ready, m_rst, m_acc;
    logic [15:0] m_count;

    always @(posedge clk) begin
        m_rst = rst;
        if (rst) begin
            cur = '0; m_pix = '0; full_q.delete(); cnt = 0;
            m_held = 0; m_le = 0; m_ready = 0; m_count = '0;
        end else begin
            m_acc = pixel_valid && m_ready;
            if (block_done && m_held) m_held = 0;
            if (m_acc) begin
                cur[cnt / 4][cnt % 4] = pixel_in;
                cnt++;
                if (cnt == 16) begin
                    full_q.push_back(cur);
                    cnt = 0;
                end
            end
            m_le = 0;
            if (!m_held && full_q.size() > 0) begin
                m_pix   = full_q.pop_front();
                m_held  = 1;
                m_le    = 1;
                m_count = m_count + 16'd1;
            end
            m_ready = (int'(m_held) + full_q.size()) < NB;
        end
        #1;
        chk("pixel_ready", pixel_ready, m_ready);
        chk("load_enable", load_enable, m_le);
        chk("busy", busy, m_held);
        chk("block_count", block_count, m_count);
        if (m_held || m_rst) chk("block_pixels", block_pixels, m_pix);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v);
        bit rdy;
        pixel_valid = v;
        pixel_in    = pv(k) + 4'(ofs);
        rdy         = pixel_ready;
        tick();
        if (v && rdy) k++;
    endtask

    task automatic do_reset();
        rst = 1; pixel_valid = 0; block_done = 0; pixel_in = 0;
        tick();
        tick();
        rst = 0; k = 0;
    endtask

    task automatic stream_until_load(input int budget, input int pct, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            drive($urandom_range(0, 99) < pct);
            if (load_enable) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL load_wait: got no load_enable expected one within %0d cycles", budget);
        end
    endtask

    int          cyc;
    int          extra_le;
    block_t      saved_pix;
    logic [15:0] saved_cnt;

    initial begin
        do_reset();
        chk("reset_ready", pixel_ready, 0);
        chk("reset_load", load_enable, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", block_count, 0);
        chk("reset_pixels", block_pixels, 0);

        // Back-to-back first block, downstream never done.
        stream_until_load(60, 100, cyc);
        chk("first_load_cycle", cyc, 17);
        chk("pix_1_2", block_pixels[1][2], 6);
        chk("first_busy", busy, 1);
        chk("first_count", block_count, 1);

        extra_le = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1);
            if (load_enable) extra_le++;
        end
        chk("accepts_before_stall", k, 16 * NB);
        chk("stall_ready", pixel_ready, 0);
        chk("extra_loads", extra_le, 0);

        block_done = 1;
        drive(0);
        block_done = 0;
`ifdef BLOCK_LOADER_PINGPONG_EN
        chk("second_load", load_enable, 1);
        chk("second_block", block_pixels, ramp(16));
        chk("second_count", block_count, 2);
        chk("second_busy", busy, 1);
`else
        chk("done_busy", busy, 0);
        chk("done_load", load_enable, 0);
        chk("done_count", block_count, 1);
`endif
        chk("done_ready", pixel_ready, 1);
        drive(0);
        chk("load_one_pulse", load_enable, 0);
`ifdef BLOCK_LOADER_PINGPONG_EN
        block_done = 1;
        drive(0);
        block_done = 0;
        drive(0);
`endif
        // block_done with nothing held must change nothing.
        saved_pix = block_pixels;
        saved_cnt = block_count;
        block_done = 1;
        drive(0);
        block_done = 0;
        drive(0);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ready", pixel_ready, 1);
        chk("idle_done_count", block_count, saved_cnt);
        chk("idle_done_pixels", block_pixels, saved_pix);

        // Reset after a partial block.
        do_reset();
        ofs = 8;
        for (int c = 0; c < 40 && k < 9; c++) drive(1);
        chk("partial_accepts", k, 9);
        rst = 1;
        drive(0);
        rst = 0; k = 0; ofs = 0;
        stream_until_load(60, 100, cyc);
        chk("rst_block", block_pixels, ramp(0));
        chk("rst_count", block_count, 1);

        // Gappy valid must assemble the same block.
        do_reset();
        stream_until_load(400, 50, cyc);
        chk("gappy_block", block_pixels, ramp(0));
        chk("gappy_count", block_count, 1);

        // Random soak against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            block_done = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            ofs        = int'($urandom);
            drive($urandom_range(0, 1) == 1);
        end
        rst = 0; block_done = 0;
        drive(0);
        drive(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
